// File: rtl/ldpc_rx_packer_if.sv
// Byte-stream input and decoder handshake bundle for ldpc_rx_packer.
// The slave modport is the packer side; master is the source/decoder side.
interface ldpc_rx_packer_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_sync;
    logic         free;
    logic         work;
    logic [255:0] tx;

    modport master (
        output in_data, in_valid, in_sync, free,
        input  in_ready, work, tx
    );

    modport slave (
        input  in_data, in_valid, in_sync, free,
        output in_ready, work, tx
    );
endinterface

// File: rtl/ldpc_rx_packer.sv
// Packs received bytes into 256-bit codewords (ping-pong buffers) and issues them to the decoder.
// Optional issued-codeword counter enabled by defining LDPC_PACKER_FRAME_CNT_EN.
module ldpc_rx_packer #(
    parameter int FRAME_BYTES = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    ldpc_rx_packer_if.slave   bus,
    output logic              ack_err,
    output logic [15:0]       frame_cnt
);
    localparam int FRAME_BITS = FRAME_BYTES * 8;
    localparam int CW         = $clog2(FRAME_BYTES);
    localparam int TW         = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t                state_reg;
    logic [CW-1:0]         cnt_reg;
    logic                  fill_sel_reg;
    logic                  issue_sel_reg;
    logic                  work_reg;
    logic                  ack_err_reg;
    logic [FRAME_BITS-1:0] tx_reg;
    logic [TW-1:0]         timer_reg;

    logic [1:0]            full_vec;
    logic [FRAME_BITS-1:0] data_vec [2];
    logic                  accept;
    logic                  frame_done;
    logic [CW-1:0]         wr_idx;
    logic                  pend_full;
    logic [FRAME_BITS-1:0] pend_data;

    assign bus.in_ready = ~rst & ~(&full_vec);
    assign accept       = bus.in_valid & bus.in_ready;
    // A resync byte always starts a new frame at position 0.
    assign wr_idx       = bus.in_sync ? '0 : cnt_reg;
    assign frame_done   = accept & (wr_idx == CNT_LAST);
    assign pend_full    = full_vec[issue_sel_reg];
    assign pend_data    = data_vec[issue_sel_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic                  full_reg;
            logic [FRAME_BITS-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (accept && fill_sel_reg == 1'(gi))
                    data_reg[{wr_idx, 3'b000} +: 8] <= bus.in_data;
            end

            // Set and clear never collide: a buffer is filled only while empty and released only while full.
            always_ff @(posedge clk) begin
                if (rst)
                    full_reg <= 1'b0;
                else if (frame_done && fill_sel_reg == 1'(gi))
                    full_reg <= 1'b1;
                else if (state_reg == ISSUE && issue_sel_reg == 1'(gi))
                    full_reg <= 1'b0;
            end

            assign full_vec[gi] = full_reg;
            assign data_vec[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            fill_sel_reg  <= 1'b0;
            issue_sel_reg <= 1'b0;
            work_reg      <= 1'b0;
            ack_err_reg   <= 1'b0;
            tx_reg        <= '0;
            timer_reg     <= '0;
        end else begin
            if (accept)
                cnt_reg <= wr_idx + 1'b1;
            else if (bus.in_sync)
                cnt_reg <= '0;
            if (frame_done)
                fill_sel_reg <= ~fill_sel_reg;

            work_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pend_full && bus.free) begin
                        tx_reg    <= pend_data;
                        work_reg  <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    issue_sel_reg <= ~issue_sel_reg;
                    timer_reg     <= '0;
                    state_reg     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!bus.free) begin
                        state_reg <= IDLE;
                    end else if (timer_reg == TO_LAST) begin
                        ack_err_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.work = work_reg;
    assign bus.tx   = tx_reg;
    assign ack_err  = ack_err_reg;

`ifdef LDPC_PACKER_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)
            frame_cnt_reg <= '0;
        else if (work_reg)
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end

    assign frame_cnt = frame_cnt_reg;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_ldpc_rx_packer.sv
// Directed self-checking bench for ldpc_rx_packer, with a simple decoder handshake model.
module tb_ldpc_rx_packer;
`ifdef LDPC_PACKER_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ack_err;
    logic [15:0] frame_cnt;

    ldpc_rx_packer_if bus ();

    ldpc_rx_packer #(.FRAME_BYTES(32), .ACK_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .ack_err   (ack_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int work_cnt = 0;
    int work_cyc = 0;
    int stall_cnt = 0;
    int free_hold = 0;
    bit model_en = 1'b0;
    bit acc_last = 1'b0;
    logic [255:0] got_q [$];

    // One clock: note acceptance before the edge, sample outputs 1ns after it, run decoder model.
    task automatic tick();
        acc_last = bus.in_valid && bus.in_ready;
        if (bus.in_valid && !bus.in_ready) stall_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.work === 1'b1) begin
            work_cnt++;
            work_cyc = cyc;
            got_q.push_back(bus.tx);
            if (model_en) begin
                bus.free  = 1'b0;
                free_hold = 12;
            end
        end else if (model_en && free_hold > 0) begin
            free_hold--;
            if (free_hold == 0) bus.free = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit s);
        int tries;
        tries = 0;
        bus.in_data  = b;
        bus.in_sync  = s;
        bus.in_valid = 1'b1;
        do begin
            tick();
            tries++;
        end while (!acc_last && tries < 200);
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
    endtask

    task automatic send_frame(input logic [255:0] f);
        for (int k = 0; k < 32; k++) send_byte(f[8*k +: 8], 1'b0);
    endtask

    task automatic wait_work(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && work_cnt < target; i++) tick();
        ok = (work_cnt >= target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.work !== 1'b0) begin errors++; $display("FAIL reset_work: got %b want 0", bus.work); end
        checks++; if (bus.tx !== 256'd0) begin errors++; $display("FAIL reset_tx: got %h want 0", bus.tx); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        logic [255:0] exp;
        int t0;
        bit ok;
        for (int k = 0; k < 32; k++) exp[8*k +: 8] = 8'(k);
        model_en = 1'b1;
        bus.free = 1'b1;
        got_q.delete();
        send_frame(exp);
        t0 = cyc;
        wait_work(1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_work_seen: got %0d pulses want 1", work_cnt); end
        checks++; if (work_cyc !== t0 + 1) begin errors++; $display("FAIL single_latency: got work at edge %0d want %0d", work_cyc, t0 + 1); end
        checks++; if (bus.tx !== exp) begin errors++; $display("FAIL single_tx: got %h want %h", bus.tx, exp); end
        idle(20);
        checks++; if (work_cnt !== 1) begin errors++; $display("FAIL single_pulse_count: got %0d want 1", work_cnt); end
        checks++; if (frame_cnt !== 16'(CNT_EN ? 1 : 0)) begin errors++; $display("FAIL single_frame_cnt: got %0d want %0d", frame_cnt, CNT_EN ? 1 : 0); end
        $display("test_single_frame done: tx=%h", bus.tx);
    endtask

    task automatic test_backpressure();
        logic [255:0] exp0, exp1;
        int base;
        bit ok;
        for (int k = 0; k < 32; k++) begin
            exp0[8*k +: 8] = 8'(k);
            exp1[8*k +: 8] = 8'(k + 32);
        end
        model_en  = 1'b0;
        bus.free  = 1'b0;
        base      = work_cnt;
        stall_cnt = 0;
        got_q.delete();
        send_frame(exp0);
        send_frame(exp1);
        checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL bp_accept_64: got %0d stalls want 0", stall_cnt); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", bus.in_ready); end
        idle(5);
        checks++; if (work_cnt !== base) begin errors++; $display("FAIL bp_no_issue: got %0d pulses want %0d", work_cnt, base); end
        model_en = 1'b1;
        bus.free = 1'b1;
        wait_work(base + 1, 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_first_issue: got %0d pulses want %0d", work_cnt, base + 1); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_in_issue: got %b want 0", bus.in_ready); end
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_issue: got %b want 1", bus.in_ready); end
        wait_work(base + 2, 60, ok);
        checks++; if (!ok || got_q.size() != 2) begin errors++; $display("FAIL bp_second_issue: got %0d codewords want 2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== exp0) begin errors++; $display("FAIL bp_tx0: got %h want %h", got_q[0], exp0); end
            checks++; if (got_q[1] !== exp1) begin errors++; $display("FAIL bp_tx1: got %h want %h", got_q[1], exp1); end
        end
        idle(20);
        $display("test_backpressure done: %0d codewords", got_q.size());
    endtask

    task automatic test_sync();
        logic [255:0] exp;
        int base;
        bit ok;
        exp[7:0] = 8'hAA;
        for (int k = 1; k < 32; k++) exp[8*k +: 8] = 8'(8'h60 + k);
        model_en = 1'b1;
        base     = work_cnt;
        got_q.delete();
        for (int k = 0; k < 10; k++) send_byte(8'(8'h50 + k), 1'b0);
        send_byte(8'hAA, 1'b1);
        for (int k = 1; k < 32; k++) send_byte(exp[8*k +: 8], 1'b0);
        wait_work(base + 1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sync_issue: got %0d pulses want %0d", work_cnt, base + 1); end
        checks++; if (bus.tx[7:0] !== 8'hAA) begin errors++; $display("FAIL sync_byte0: got %h want aa", bus.tx[7:0]); end
        checks++; if (bus.tx !== exp) begin errors++; $display("FAIL sync_tx: got %h want %h", bus.tx, exp); end
        idle(20);
        checks++; if (work_cnt !== base + 1) begin errors++; $display("FAIL sync_single_pulse: got %0d want %0d", work_cnt, base + 1); end
        checks++; if (frame_cnt !== 16'(CNT_EN ? 4 : 0)) begin errors++; $display("FAIL sync_frame_cnt: got %0d want %0d", frame_cnt, CNT_EN ? 4 : 0); end
        $display("test_sync done: tx=%h", bus.tx);
    endtask

    task automatic test_ack_timeout();
        logic [255:0] exp0, exp1;
        int base, tw;
        bit ok;
        for (int k = 0; k < 32; k++) begin
            exp0[8*k +: 8] = 8'(8'h80 + k);
            exp1[8*k +: 8] = 8'(8'hFF - k);
        end
        model_en = 1'b0;
        bus.free = 1'b1;
        base     = work_cnt;
        send_frame(exp0);
        wait_work(base + 1, 20, ok);
        tw = cyc;
        checks++; if (!ok) begin errors++; $display("FAIL to_issue: got %0d pulses want %0d", work_cnt, base + 1); end
        idle(13);
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL to_ack_early: got %b want 0 at edge %0d", ack_err, cyc - tw); end
        idle(4);
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL to_ack_set: got %b want 1", ack_err); end
        model_en = 1'b1;
        send_frame(exp1);
        wait_work(base + 2, 20, ok);
        checks++; if (!ok || bus.tx !== exp1) begin errors++; $display("FAIL to_reissue: got %h want %h", bus.tx, exp1); end
        idle(20);
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL to_ack_sticky: got %b want 1", ack_err); end
        $display("test_ack_timeout done: ack_err=%b", ack_err);
    endtask

    task automatic test_reset_mid_frame();
        logic [255:0] exp;
        int base;
        bit ok;
        for (int k = 0; k < 32; k++) exp[8*k +: 8] = 8'(8'hE0 ^ (k * 3));
        model_en = 1'b1;
        for (int k = 0; k < 20; k++) send_byte(8'(8'h11 * k), 1'b0);
        do_reset();
        base = work_cnt;
        idle(40);
        checks++; if (work_cnt !== base) begin errors++; $display("FAIL rstmid_no_work: got %0d pulses want %0d", work_cnt, base); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rstmid_ack_clear: got %b want 0", ack_err); end
        send_frame(exp);
        wait_work(base + 1, 20, ok);
        checks++; if (!ok || bus.tx !== exp) begin errors++; $display("FAIL rstmid_tx: got %h want %h", bus.tx, exp); end
        idle(20);
        checks++; if (frame_cnt !== 16'(CNT_EN ? 1 : 0)) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d want %0d", frame_cnt, CNT_EN ? 1 : 0); end
        $display("test_reset_mid_frame done: frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp_f [100];
        int base, bad;
        bit ok;
        for (int f = 0; f < 100; f++)
            for (int w = 0; w < 8; w++) exp_f[f][32*w +: 32] = $urandom;
        do_reset();
        bus.free  = 1'b1;
        free_hold = 0;
        model_en  = 1'b1;
        idle(2);
        base      = work_cnt;
        stall_cnt = 0;
        got_q.delete();
        for (int f = 0; f < 100; f++) send_frame(exp_f[f]);
        wait_work(base + 100, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_count: got %0d codewords want 100", work_cnt - base); end
        checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", stall_cnt); end
        bad = 0;
        for (int f = 0; f < 100 && f < got_q.size(); f++) begin
            checks++;
            if (got_q[f] !== exp_f[f]) begin
                errors++;
                bad++;
                $display("FAIL b2b_tx[%0d]: got %h want %h", f, got_q[f], exp_f[f]);
            end
        end
        idle(20);
        checks++; if (frame_cnt !== 16'(CNT_EN ? 100 : 0)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt, CNT_EN ? 100 : 0); end
        $display("test_back_to_back done: %0d codewords, %0d bad", got_q.size(), bad);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.free     = 1'b1;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_sync();
        test_ack_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
